// File: rtl/matrix_scan_pkg.sv
// Shared constants and types for the LED matrix scanner.
// Also used by the 6-bit-code pixel decoder.
package matrix_scan_pkg;

    localparam int NUM_COLS   = 5;
    localparam int NUM_ROWS   = 7;
    localparam int NUM_PIXELS = NUM_COLS * NUM_ROWS;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Column k lives in bits [34-7k : 28-7k]; the MSB is the upper row.
    function automatic logic [NUM_ROWS-1:0] col_bits(
        input logic [NUM_PIXELS-1:0] map,
        input logic [2:0]            idx
    );
        logic [NUM_ROWS-1:0] r;
        r = '0;
        case (idx)
            3'd0:    r = map[34:28];
            3'd1:    r = map[27:21];
            3'd2:    r = map[20:14];
            3'd3:    r = map[13:7];
            3'd4:    r = map[6:0];
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with terminal-count flag.
// Holds at zero; tc stays high until the next load.
module scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Clear wins over load; count down and stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/matrix_scan.sv
// Column-multiplexed 5x7 LED scanner with double-buffered pattern.
// New patterns are shown only from a frame boundary onward.
module matrix_scan
    import matrix_scan_pkg::*;
#(
    parameter int DWELL = 50000,
    parameter int BLANK = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [NUM_PIXELS-1:0] pattern,
    output logic [NUM_COLS-1:0]   col,
    output logic [NUM_ROWS-1:0]   row,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int MAXT = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXT);

    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [2:0]    LAST_COL = 3'(NUM_COLS - 1);
    localparam logic [NUM_ROWS-1:0] ROWS_OFF = '1;

    scan_state_t           state, state_n;
    logic [2:0]            cidx, cidx_n;
    logic                  fresh, fresh_n;
    logic [NUM_PIXELS-1:0] shadow, disp;
    logic [NUM_COLS-1:0]   col_n;
    logic [NUM_ROWS-1:0]   row_n;
    logic                  tick_n;
    logic                  swap;
    logic                  t_clr, t_ld, t_tc;
    logic [CW-1:0]         t_val;

    scan_timer #(
        .W(CW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (t_clr),
        .ld    (t_ld),
        .ld_val(t_val),
        .tc    (t_tc)
    );

    // State, column index and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cidx       <= '0;
            fresh      <= 1'b1;
            col        <= '0;
            row        <= ROWS_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            cidx       <= cidx_n;
            fresh      <= fresh_n;
            col        <= col_n;
            row        <= row_n;
            frame_tick <= tick_n;
        end
    end

    // Double buffer: load fills shadow, frame wrap copies it to disp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            if (load) shadow <= pattern;
            if (swap) disp <= shadow;
            pending <= load | (pending & ~swap);
        end
    end

    // Next state: fresh marks a scan that must begin with a full blank.
    always_comb begin
        state_n = state;
        cidx_n  = cidx;
        fresh_n = fresh;
        col_n   = col;
        row_n   = row;
        tick_n  = 1'b0;
        swap    = 1'b0;
        t_clr   = 1'b0;
        t_ld    = 1'b0;
        t_val   = '0;
        if (!en) begin
            state_n = ST_BLANK;
            cidx_n  = '0;
            fresh_n = 1'b1;
            t_clr   = 1'b1;
            col_n   = '0;
            row_n   = ROWS_OFF;
        end else if (fresh) begin
            fresh_n = 1'b0;
            t_ld    = 1'b1;
            t_val   = BLANK_LD;
            col_n   = '0;
            row_n   = ROWS_OFF;
        end else if (t_tc) begin
            unique case (state)
                ST_BLANK: begin
                    state_n = ST_DRIVE;
                    t_ld    = 1'b1;
                    t_val   = DWELL_LD;
                    col_n   = NUM_COLS'(1) << cidx;
                    row_n   = ~col_bits(disp, cidx);
                end
                ST_DRIVE: begin
                    state_n = ST_BLANK;
                    t_ld    = 1'b1;
                    t_val   = BLANK_LD;
                    col_n   = '0;
                    row_n   = ROWS_OFF;
                    if (cidx == LAST_COL) begin
                        cidx_n = '0;
                        tick_n = 1'b1;
                        swap   = pending;
                    end else begin
                        cidx_n = cidx + 3'd1;
                    end
                end
                default: begin
                    state_n = ST_BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan with DWELL=4, BLANK=2.
// Table of per-edge vectors plus hand-written corner sequences.
module tb_matrix_scan;

    localparam int NV = 40;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [34:0] pattern;
    logic [4:0]  col;
    logic [6:0]  row;
    logic        frame_tick;
    logic        pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        load;
        logic [34:0] pattern;
        logic [4:0]  col;
        logic [6:0]  row;
        logic        ft;
        logic        pend;
    } vec_t;

    vec_t vt [NV];

    matrix_scan #(
        .DWELL(4),
        .BLANK(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .pattern   (pattern),
        .col       (col),
        .row       (row),
        .frame_tick(frame_tick),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [34:0] act,
                       input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [4:0] c);
        int n;
        n = 0;
        while (col !== c && n < 100) begin
            cyc(1);
            n++;
        end
        if (col !== c) begin
            errors++;
            checks++;
            $display("FAIL wait_col timeout col=%b want %b", col, c);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        cyc(1);
        while (frame_tick !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        if (frame_tick !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL wait_tick timeout");
        end
    endtask

    initial begin
        int e, pos, q, c, r, n, bl;
        int cc [5];
        logic [4:0] ec;

        // Expected per-edge results after reset release, en=1 throughout.
        for (int i = 0; i < NV; i++) begin
            e   = i + 1;
            pos = (e - 1) % 30;
            ec  = 5'b0;
            if (pos >= 2) begin
                q = pos - 2;
                c = q / 6;
                r = q % 6;
                if (r < 4) ec = 5'(1 << c);
            end
            vt[i].load    = (i == 0);
            vt[i].pattern = (i == 0) ? 35'h4_0000_0000 : 35'h0;
            vt[i].col     = ec;
            vt[i].row     = (e >= 31 && ec == 5'b00001) ? 7'b0111111 : 7'h7F;
            vt[i].ft      = (e == 31);
            vt[i].pend    = (e <= 30);
        end

        rst_n   = 1'b0;
        en      = 1'b1;
        load    = 1'b0;
        pattern = '0;
        #12;
        chk("rst_col", 35'(col), 35'h0);
        chk("rst_row", 35'(row), 35'h7F);
        chk("rst_ft", 35'(frame_tick), 35'h0);
        chk("rst_pend", 35'(pending), 35'h0);
        cyc(1);
        rst_n = 1'b1;

        // Table: inputs before edge i+1, outputs sampled after it.
        for (int i = 0; i < NV; i++) begin
            load    = vt[i].load;
            pattern = vt[i].pattern;
            cyc(1);
            chk($sformatf("v%0d_col", i), 35'(col), 35'(vt[i].col));
            chk($sformatf("v%0d_row", i), 35'(row), 35'(vt[i].row));
            chk($sformatf("v%0d_ft", i), 35'(frame_tick), 35'(vt[i].ft));
            chk($sformatf("v%0d_pend", i), 35'(pending), 35'(vt[i].pend));
        end
        load = 1'b0;

        // Frame period and per-column dwell.
        wait_tick();
        n  = 0;
        bl = 0;
        for (int k = 0; k < 5; k++) cc[k] = 0;
        do begin
            cyc(1);
            n++;
            case (col)
                5'b00000: bl++;
                5'b00001: cc[0]++;
                5'b00010: cc[1]++;
                5'b00100: cc[2]++;
                5'b01000: cc[3]++;
                5'b10000: cc[4]++;
                default:  bl += 100;
            endcase
        end while (frame_tick !== 1'b1 && n < 60);
        chk("period", 35'(n), 35'd30);
        chk("blank_cnt", 35'(bl), 35'd10);
        for (int k = 0; k < 5; k++)
            chk($sformatf("dwell_c%0d", k), 35'(cc[k]), 35'd4);

        // Two loads in one frame: the last wins.
        load    = 1'b1;
        pattern = 35'h7F;
        cyc(1);
        load = 1'b0;
        cyc(3);
        load    = 1'b1;
        pattern = 35'h1;
        cyc(1);
        load = 1'b0;
        chk("ll_pend", 35'(pending), 35'h1);
        wait_tick();
        chk("ll_pend_drop", 35'(pending), 35'h0);
        wait_col(5'b00001);
        chk("ll_c0", 35'(row), 35'h7F);
        wait_col(5'b10000);
        chk("ll_c4", 35'(row), 35'b1111110);

        // Load landing on the exact wrap edge.
        wait_tick();
        load    = 1'b1;
        pattern = 35'h7F;
        cyc(1);
        load = 1'b0;
        cyc(28);
        load    = 1'b1;
        pattern = 35'h3F80;
        cyc(1);
        load = 1'b0;
        chk("wr_ft", 35'(frame_tick), 35'h1);
        chk("wr_pend", 35'(pending), 35'h1);
        wait_col(5'b01000);
        chk("wr_c3a", 35'(row), 35'h7F);
        wait_col(5'b10000);
        chk("wr_c4a", 35'(row), 35'h00);
        wait_tick();
        chk("wr_pend2", 35'(pending), 35'h0);
        wait_col(5'b01000);
        chk("wr_c3b", 35'(row), 35'h00);
        wait_col(5'b10000);
        chk("wr_c4b", 35'(row), 35'h7F);

        // Enable drop during column 2.
        wait_col(5'b00100);
        en = 1'b0;
        cyc(1);
        chk("en0_col", 35'(col), 35'h0);
        chk("en0_row", 35'(row), 35'h7F);
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (frame_tick !== 1'b0 || col !== 5'b0) break;
        end
        chk("en0_hold_ft", 35'(frame_tick), 35'h0);
        chk("en0_hold_col", 35'(col), 35'h0);
        en = 1'b1;
        cyc(1);
        chk("en1_b1", 35'(col), 35'h0);
        cyc(1);
        chk("en1_b2", 35'(col), 35'h0);
        cyc(1);
        chk("en1_c0", 35'(col), 35'b00001);
        chk("en1_row", 35'(row), 35'h7F);

        // Asynchronous reset in the middle of a drive period.
        load    = 1'b1;
        pattern = 35'h1;
        cyc(1);
        load = 1'b0;
        wait_col(5'b00100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_col", 35'(col), 35'h0);
        chk("ar_row", 35'(row), 35'h7F);
        chk("ar_ft", 35'(frame_tick), 35'h0);
        chk("ar_pend", 35'(pending), 35'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("ar_b1", 35'(col), 35'h0);
        cyc(2);
        chk("ar_c0", 35'(col), 35'b00001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
